// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Responder end of the cache-to-memory interface. Services single-word
//   requests from the icache (read only) and the dcache (read/write) against
//   one RAM port. The dcache has priority. A streak counter lets the icache
//   win after STARVE_MAX consecutive dcache completions that each saw iREN
//   pending.
//
// Ports
//   CLK, nRST              clock, asynchronous active-low reset
//   iREN, iaddr            icache read request and word address
//   iwait, iload           icache handshake (0 for one cycle = data valid), load data
//   dREN, dWEN             dcache read / write request (write wins if both)
//   daddr, dstore          dcache word address and store data
//   dwait, dload           dcache handshake (0 for one cycle = done), load data
//   ramREN, ramWEN         RAM enables, decoded from the grant state
//   ramaddr, ramstore      RAM address / write data, passed through from the grantee
//   ramload, ramstate      RAM read data and status (FREE, BUSY, ACCESS, ERROR)
//   mem_err                sticky flag, set when any grant completes with ERROR
module cache_mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter logic [31:0] ERR_WORD   = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    // icache side
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    // dcache side
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    // RAM side
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    // status
    output logic        mem_err
);

    localparam int unsigned StreakW = $clog2(STARVE_MAX + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(STARVE_MAX);

    // ramstate_t encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3
    localparam logic [1:0] RamAccess = 2'd2;
    localparam logic [1:0] RamError  = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StDgnt,
        StIgnt
    } state_e;

    state_e               state_q, state_d;
    logic [StreakW-1:0]   dstreak_q, dstreak_d;
    logic                 mem_err_q, mem_err_d;

    logic                 d_req;
    logic                 starve;
    logic                 ram_done;
    logic                 ram_err;

    assign d_req    = dREN | dWEN;
    assign starve   = (dstreak_q == StreakMax);
    assign ram_err  = (ramstate == RamError);
    // A grant finishes on ACCESS or ERROR; FREE/BUSY just hold it.
    assign ram_done = (ramstate == RamAccess) || ram_err;
    assign mem_err  = mem_err_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= StIdle;
            dstreak_q <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dstreak_d = dstreak_q;
        mem_err_d = mem_err_q;
        iwait     = 1'b1;
        dwait     = 1'b1;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        iload     = ramload;
        dload     = ramload;

        case (state_q)
            StIdle: begin
                // Arbitration cycle: no RAM enable is driven here.
                if (d_req && !(starve && iREN)) begin
                    state_d = StDgnt;
                end else if (iREN) begin
                    state_d = StIgnt;
                end
            end

            StDgnt: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (!d_req) begin
                    // Requester withdrew: silent abort, counters untouched.
                    state_d = StIdle;
                end else if (ram_done) begin
                    dwait   = 1'b0;
                    state_d = StIdle;
                    if (ram_err) begin
                        dload     = ERR_WORD;
                        mem_err_d = 1'b1;
                    end
                    // Only completions that actually held off the icache
                    // count towards starvation.
                    if (iREN) begin
                        if (!starve) begin
                            dstreak_d = dstreak_q + StreakW'(1);
                        end
                    end else begin
                        dstreak_d = '0;
                    end
                end
            end

            StIgnt: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (!iREN) begin
                    state_d = StIdle;
                end else if (ram_done) begin
                    iwait     = 1'b0;
                    state_d   = StIdle;
                    dstreak_d = '0;
                    if (ram_err) begin
                        iload     = ERR_WORD;
                        mem_err_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

    localparam int          STARVE = 4;
    localparam logic [31:0] ERRW   = 32'hBAD1BAD1;
    localparam logic [1:0]  RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;
    localparam int          LAT    = 2;

    logic        CLK, nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        iwait, dwait, ramREN, ramWEN, mem_err;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [1:0]  ramstate;

    int checks, errors;

    // RAM model: LAT-cycle accesses, with hooks to stall or fail them.
    logic [31:0] mem    [256];
    logic [31:0] shadow [256];
    logic        poke_en;
    logic [7:0]  poke_addr;
    logic [31:0] poke_data;
    logic        hold_busy, inject_err;
    int          cnt;

    cache_mem_arbiter #(.STARVE_MAX(STARVE), .ERR_WORD(ERRW)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign ramload = mem[ramaddr[7:0]];

    always_comb begin
        if (!(ramREN || ramWEN))               ramstate = RS_FREE;
        else if (hold_busy || cnt < LAT - 1)   ramstate = RS_BUSY;
        else if (inject_err)                   ramstate = RS_ERROR;
        else                                   ramstate = RS_ACCESS;
    end

    always @(posedge CLK or negedge nRST) begin
        if (!nRST)                  cnt <= 0;
        else if (ramstate == RS_BUSY) cnt <= cnt + 1;
        else                        cnt <= 0;
    end

    always @(posedge CLK) begin
        if (poke_en)                             mem[poke_addr] <= poke_data;
        else if (ramWEN && ramstate == RS_ACCESS) mem[ramaddr[7:0]] <= ramstore;
    end

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge CLK);
        poke_en = 1'b0;
        shadow[a] = d;
    endtask

    // Requester helpers: hold the request through the completion edge, then drop it.
    task automatic d_xact(input logic ren, input logic wen, input logic [31:0] addr,
                          input logic [31:0] data, output logic [31:0] rd, output bit ok);
        dREN = ren; dWEN = wen; daddr = addr; dstore = data; ok = 1'b0; rd = '0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge CLK);
            if (dwait === 1'b0) begin rd = dload; ok = 1'b1; end
        end
        @(posedge CLK); #1;
        dREN = 1'b0; dWEN = 1'b0;
        @(negedge CLK);
    endtask

    task automatic i_xact(input logic [31:0] addr, output logic [31:0] rd, output bit ok);
        iREN = 1'b1; iaddr = addr; ok = 1'b0; rd = '0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge CLK);
            if (iwait === 1'b0) begin rd = iload; ok = 1'b1; end
        end
        @(posedge CLK); #1;
        iREN = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        daddr = $urandom; iaddr = $urandom; dstore = $urandom;
        for (int i = 0; i < 256; i++) poke(8'(i), $urandom);
        checks++; if (iwait !== 1'b1)    begin errors++; $display("FAIL reset_iwait got %b want 1", iwait); end
        checks++; if (dwait !== 1'b1)    begin errors++; $display("FAIL reset_dwait got %b want 1", dwait); end
        checks++; if ({ramREN, ramWEN} !== 2'b00) begin errors++; $display("FAIL reset_ram_en got %b want 00", {ramREN, ramWEN}); end
        checks++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin errors++; $display("FAIL reset_ram_bus got %h/%h want 0/0", ramaddr, ramstore); end
        checks++; if (mem_err !== 1'b0)  begin errors++; $display("FAIL reset_mem_err got %b want 0", mem_err); end
        checks++; if (dut.dstreak_q !== 3'd0) begin errors++; $display("FAIL reset_dstreak got %0d want 0", dut.dstreak_q); end
        daddr = '0; iaddr = '0; dstore = '0;
        nRST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_dcache_read();
        poke(8'h40, 32'h1234ABCD);
        dREN = 1'b1; dWEN = 1'b0; daddr = 32'h40;
        @(negedge CLK);
        checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40 || dwait !== 1'b1) begin
            errors++; $display("FAIL dread_grant got ren=%b wen=%b addr=%h dwait=%b want 1 0 40 1", ramREN, ramWEN, ramaddr, dwait);
        end
        @(negedge CLK);
        checks++; if (dwait !== 1'b0 || dload !== 32'h1234ABCD) begin
            errors++; $display("FAIL dread_data got dwait=%b dload=%h want 0 1234abcd", dwait, dload);
        end
        @(posedge CLK); #1; dREN = 1'b0;
        @(negedge CLK);
        checks++; if (dwait !== 1'b1 || ramREN !== 1'b0) begin
            errors++; $display("FAIL dread_idle got dwait=%b ramREN=%b want 1 0", dwait, ramREN);
        end
    endtask

    task automatic test_dcache_write();
        logic [31:0] rd; bit ok; bit done;
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEADBEEF; done = 1'b0;
        @(negedge CLK);
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h80 || ramstore !== 32'hDEADBEEF) begin
            errors++; $display("FAIL dwrite_grant got wen=%b ren=%b addr=%h data=%h want 1 0 80 deadbeef", ramWEN, ramREN, ramaddr, ramstore);
        end
        for (int n = 0; n < 20 && !done; n++) begin
            if (dwait === 1'b0) done = 1'b1; else @(negedge CLK);
        end
        checks++; if (!done) begin errors++; $display("FAIL dwrite_timeout got no dwait pulse want pulse"); end
        @(posedge CLK); #1; dREN = 1'b0; dWEN = 1'b0;
        @(negedge CLK);
        shadow[8'h80] = 32'hDEADBEEF;
        d_xact(1'b1, 1'b0, 32'h80, 32'h0, rd, ok);
        checks++; if (!ok || rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL dwrite_readback got ok=%b data=%h want 1 deadbeef", ok, rd);
        end
    endtask

    task automatic test_icache_error();
        logic [31:0] rd; bit ok;
        inject_err = 1'b1;
        i_xact(32'h60, rd, ok);
        inject_err = 1'b0;
        checks++; if (!ok || rd !== ERRW) begin errors++; $display("FAIL ierr_load got ok=%b data=%h want 1 %h", ok, rd, ERRW); end
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL ierr_mem_err got %b want 1", mem_err); end
        d_xact(1'b1, 1'b0, 32'h40, 32'h0, rd, ok);
        checks++; if (!ok || rd !== shadow[8'h40]) begin errors++; $display("FAIL ierr_good_read got ok=%b data=%h want 1 %h", ok, rd, shadow[8'h40]); end
        d_xact(1'b0, 1'b1, 32'h44, 32'h0BADF00D, rd, ok);
        shadow[8'h44] = 32'h0BADF00D;
        checks++; if (!ok || mem_err !== 1'b1) begin errors++; $display("FAIL ierr_sticky got ok=%b mem_err=%b want 1 1", ok, mem_err); end
    endtask

    task automatic test_starvation();
        int streak, ncomp; bit prev_i, exp_i, got_i;
        streak = 0; ncomp = 0; prev_i = 1'b0;
        iREN = 1'b1; iaddr = 32'h10; dREN = 1'b1; dWEN = 1'b0; daddr = 32'h20;
        for (int n = 0; n < 200 && ncomp < 12; n++) begin
            @(negedge CLK);
            if (prev_i) begin
                checks++; if (dut.dstreak_q !== 3'd0) begin errors++; $display("FAIL starve_clear got %0d want 0", dut.dstreak_q); end
            end
            prev_i = 1'b0;
            if (dwait === 1'b0 && iwait === 1'b0) begin
                checks++; errors++; $display("FAIL starve_both_wait got 00 want one-hot");
            end else if (dwait === 1'b0 || iwait === 1'b0) begin
                got_i  = (iwait === 1'b0);
                exp_i  = (streak == STARVE);
                streak = exp_i ? 0 : streak + 1;
                checks++; if (got_i !== exp_i) begin
                    errors++; $display("FAIL starve_order #%0d got %s want %s", ncomp, got_i ? "I" : "D", exp_i ? "I" : "D");
                end
                checks++; if (got_i ? (iload !== shadow[8'h10]) : (dload !== shadow[8'h20])) begin
                    errors++; $display("FAIL starve_data #%0d got %h want %h", ncomp, got_i ? iload : dload, got_i ? shadow[8'h10] : shadow[8'h20]);
                end
                prev_i = got_i;
                ncomp++;
            end
        end
        checks++; if (ncomp != 12) begin errors++; $display("FAIL starve_timeout got %0d want 12", ncomp); end
        @(posedge CLK); #1; iREN = 1'b0; dREN = 1'b0;
        @(negedge CLK);
        checks++; if (dut.dstreak_q !== 3'(streak)) begin errors++; $display("FAIL starve_final got %0d want %0d", dut.dstreak_q, streak); end
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL starve_sticky got %b want 1", mem_err); end
    endtask

    task automatic test_reset_mid_grant();
        hold_busy = 1'b1; iREN = 1'b1; iaddr = 32'h10;
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h90; dstore = 32'h55AA55AA;
        @(negedge CLK);
        checks++; if (ramWEN !== 1'b1 || ramstate !== RS_BUSY) begin errors++; $display("FAIL rst_pre_grant got wen=%b st=%0d want 1 1", ramWEN, ramstate); end
        #2 nRST = 1'b0;
        #1;
        checks++; if ({ramREN, ramWEN} !== 2'b00) begin errors++; $display("FAIL rst_ram_en got %b want 00", {ramREN, ramWEN}); end
        checks++; if ({iwait, dwait} !== 2'b11) begin errors++; $display("FAIL rst_waits got %b want 11", {iwait, dwait}); end
        checks++; if (dut.dstreak_q !== 3'd0 || mem_err !== 1'b0) begin errors++; $display("FAIL rst_state got streak=%0d mem_err=%b want 0 0", dut.dstreak_q, mem_err); end
        @(negedge CLK);
        dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0; hold_busy = 1'b0; nRST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_abort();
        bit got, pulsed;
        got = 1'b0; pulsed = 1'b0;
        hold_busy = 1'b1; dREN = 1'b1; dWEN = 1'b0; daddr = 32'h30; iREN = 1'b1; iaddr = 32'h50;
        @(negedge CLK);
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h30 || iwait !== 1'b1) begin
            errors++; $display("FAIL abort_dgrant got ren=%b addr=%h iwait=%b want 1 30 1", ramREN, ramaddr, iwait);
        end
        for (int n = 0; n < 3; n++) begin
            if (dwait !== 1'b1) pulsed = 1'b1;
            @(negedge CLK);
        end
        dREN = 1'b0; hold_busy = 1'b0;
        @(negedge CLK);
        checks++; if (dwait !== 1'b1 || ramREN !== 1'b0 || dut.dstreak_q !== 3'd0) begin
            errors++; $display("FAIL abort_idle got dwait=%b ren=%b streak=%0d want 1 0 0", dwait, ramREN, dut.dstreak_q);
        end
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge CLK);
            if (dwait !== 1'b1) pulsed = 1'b1;
            if (iwait === 1'b0) begin
                got = 1'b1;
                checks++; if (iload !== shadow[8'h50]) begin errors++; $display("FAIL abort_iload got %h want %h", iload, shadow[8'h50]); end
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL abort_igrant got none want iwait pulse"); end
        checks++; if (pulsed) begin errors++; $display("FAIL abort_dwait got pulse want none"); end
        @(posedge CLK); #1; iREN = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_random();
        bit done;
        done = 1'b0;
        fork
            begin
                fork
                    begin
                        logic w; logic [7:0] a; logic [31:0] dat, rd; bit ok;
                        for (int k = 0; k < 25; k++) begin
                            repeat ($urandom_range(0, 3)) @(negedge CLK);
                            w = 1'($urandom_range(0, 1)); a = 8'($urandom_range(0, 255)); dat = $urandom;
                            d_xact(~w, w, {24'h0, a}, dat, rd, ok);
                            checks++;
                            if (!ok) begin errors++; $display("FAIL rand_d_timeout #%0d got none want dwait pulse", k); end
                            else if (w) shadow[a] = dat;
                            else if (rd !== shadow[a]) begin errors++; $display("FAIL rand_dload #%0d addr %h got %h want %h", k, a, rd, shadow[a]); end
                        end
                    end
                    begin
                        logic [7:0] a; logic [31:0] rd; bit ok;
                        for (int k = 0; k < 25; k++) begin
                            repeat ($urandom_range(0, 3)) @(negedge CLK);
                            a = 8'($urandom_range(0, 255));
                            i_xact({24'h0, a}, rd, ok);
                            checks++;
                            if (!ok) begin errors++; $display("FAIL rand_i_timeout #%0d got none want iwait pulse", k); end
                            else if (rd !== shadow[a]) begin errors++; $display("FAIL rand_iload #%0d addr %h got %h want %h", k, a, rd, shadow[a]); end
                        end
                    end
                join
                done = 1'b1;
            end
            begin
                bit pd, pi;
                pd = 1'b0; pi = 1'b0;
                while (!done) begin
                    @(negedge CLK);
                    checks++;
                    if (dwait === 1'b0 && iwait === 1'b0) begin errors++; $display("FAIL rand_both_wait got 00 want not both"); end
                    else if ((pd && dwait === 1'b0) || (pi && iwait === 1'b0)) begin errors++; $display("FAIL rand_pulse_len got 2+ cycles want 1"); end
                    pd = (dwait === 1'b0); pi = (iwait === 1'b0);
                end
            end
        join
        checks++;
        begin
            int bad; bad = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== shadow[i]) bad++;
            if (bad != 0) begin errors++; $display("FAIL rand_mem got %0d bad words want 0", bad); end
        end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL rand_mem_err got %b want 0", mem_err); end
    endtask

    initial begin
        checks = 0; errors = 0;
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        hold_busy = 1'b0; inject_err = 1'b0;
        @(negedge CLK);
        test_reset();
        test_dcache_read();
        test_dcache_write();
        test_icache_error();
        test_starvation();
        test_reset_mid_grant();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
